// File: rtl/mkii_ctrl_pkg.sv
// Shared MkII control definitions: step encoding,
// opcodes, ALU selects and sequencer state.
package mkii_ctrl_pkg;

  localparam int REG_AW    = 5;
  localparam int ALU_SEL_W = 3;
  localparam int OP_W      = 4;

  typedef enum logic [5:0] {
    I_NONE  = 6'b000000,
    I_ONE   = 6'b000001,
    I_TWO   = 6'b000010,
    I_THREE = 6'b000100,
    I_FOUR  = 6'b001000,
    I_FIVE  = 6'b010000,
    I_SIX   = 6'b100000
  } INSTRUCTION_COUNT;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLT  = 4'd5,
    OP_ADDI = 4'd8
  } OPCODE_T;

  localparam logic [ALU_SEL_W-1:0] ALU_NONE = 3'b000;
  localparam logic [ALU_SEL_W-1:0] ALU_ADD  = 3'b001;
  localparam logic [ALU_SEL_W-1:0] ALU_SUB  = 3'b010;
  localparam logic [ALU_SEL_W-1:0] ALU_AND  = 3'b011;
  localparam logic [ALU_SEL_W-1:0] ALU_OR   = 3'b100;
  localparam logic [ALU_SEL_W-1:0] ALU_XOR  = 3'b101;
  localparam logic [ALU_SEL_W-1:0] ALU_SLT  = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_S1,
    ST_S2,
    ST_S3,
    ST_S4,
    ST_ERR
  } state_t;

  typedef struct packed {
    logic                 legal;
    logic                 uses_imm;
    logic [ALU_SEL_W-1:0] alu_sel;
  } dec_t;

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction issue handshake into the sequencer.
interface instr_sequencer_if;
  import mkii_ctrl_pkg::*;

  logic              instr_valid;
  logic              instr_ready;
  logic [OP_W-1:0]   op;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;

  modport master (
    output instr_valid, op, rd, rs1, rs2,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, op, rd, rs1, rs2,
    output instr_ready
  );

endinterface

// File: rtl/instr_decode.sv
// Combinational opcode decode: legality,
// immediate use and ALU select.
module instr_decode
  import mkii_ctrl_pkg::*;
(
  input  logic [OP_W-1:0] op_i,
  output dec_t            dec_o
);

  always_comb begin
    dec_o = '{legal: 1'b0, uses_imm: 1'b0,
              alu_sel: ALU_NONE};
    unique case (1'b1)
      (op_i == OP_ADD):  dec_o = '{1'b1, 1'b0, ALU_ADD};
      (op_i == OP_SUB):  dec_o = '{1'b1, 1'b0, ALU_SUB};
      (op_i == OP_AND):  dec_o = '{1'b1, 1'b0, ALU_AND};
      (op_i == OP_OR):   dec_o = '{1'b1, 1'b0, ALU_OR};
      (op_i == OP_XOR):  dec_o = '{1'b1, 1'b0, ALU_XOR};
      (op_i == OP_SLT):  dec_o = '{1'b1, 1'b0, ALU_SLT};
      (op_i == OP_ADDI): dec_o = '{1'b1, 1'b1, ALU_ADD};
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// MkII execute-path micro-sequencer: four one-hot
// steps per instruction, always-driven enables.
module instr_sequencer
  import mkii_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hold,
  instr_sequencer_if.slave     bus,
  output logic [5:0]           function_ctr,
  output logic [REG_AW-1:0]    reg_index,
  output logic                 reg_r_en,
  output logic                 reg_w_en,
  output logic                 alu1_w_en,
  output logic                 alu2_w_en,
  output logic                 alu0_r_en,
  output logic                 imm_en,
  output logic [ALU_SEL_W-1:0] alu_function_sel,
  output logic                 done,
  output logic                 illegal
);

  state_t               state_q, state_d;
  logic [REG_AW-1:0]    rd_q, rd_d;
  logic [REG_AW-1:0]    rs1_q, rs1_d;
  logic [REG_AW-1:0]    rs2_q, rs2_d;
  logic                 imm_q, imm_d;
  logic [ALU_SEL_W-1:0] sel_q, sel_d;
  logic                 err_new_q, err_new_d;
  dec_t                 dec;
  logic                 accept;

  instr_decode u_dec (
    .op_i  (bus.op),
    .dec_o (dec)
  );

  assign bus.instr_ready = !hold &&
    (state_q == ST_IDLE || state_q == ST_S4 ||
     state_q == ST_ERR);
  assign accept = bus.instr_valid && bus.instr_ready;

  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    imm_d     = imm_q;
    sel_d     = sel_q;
    err_new_d = 1'b0;
    if (accept) begin
      rd_d      = bus.rd;
      rs1_d     = bus.rs1;
      rs2_d     = bus.rs2;
      imm_d     = dec.uses_imm;
      sel_d     = dec.alu_sel;
      err_new_d = !dec.legal;
      state_d   = dec.legal ? ST_S1 : ST_ERR;
    end else if (!hold) begin
      unique case (state_q)
        ST_S1:         state_d = ST_S2;
        ST_S2:         state_d = ST_S3;
        ST_S3:         state_d = ST_S4;
        ST_S4, ST_ERR: state_d = ST_IDLE;
        default:       state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= 1'b0;
      sel_q     <= '0;
      err_new_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      imm_q     <= imm_d;
      sel_q     <= sel_d;
      err_new_q <= err_new_d;
    end
  end

  // Enables decode only registered state; done alone sees hold.
  always_comb begin
    function_ctr     = I_NONE;
    reg_index        = '0;
    reg_r_en         = 1'b0;
    reg_w_en         = 1'b0;
    alu1_w_en        = 1'b0;
    alu2_w_en        = 1'b0;
    alu0_r_en        = 1'b0;
    imm_en           = 1'b0;
    alu_function_sel = '0;
    done             = 1'b0;
    illegal          = 1'b0;
    unique case (state_q)
      ST_S1: begin
        function_ctr     = I_ONE;
        alu_function_sel = sel_q;
        reg_index        = rs1_q;
        reg_r_en         = 1'b1;
        alu1_w_en        = 1'b1;
      end
      ST_S2: begin
        function_ctr     = I_TWO;
        alu_function_sel = sel_q;
        alu2_w_en        = 1'b1;
        if (imm_q) begin
          imm_en = 1'b1;
        end else begin
          reg_index = rs2_q;
          reg_r_en  = 1'b1;
        end
      end
      ST_S3: begin
        function_ctr     = I_THREE;
        alu_function_sel = sel_q;
        reg_index        = rd_q;
        alu0_r_en        = 1'b1;
        reg_w_en         = |rd_q;
      end
      ST_S4: begin
        function_ctr     = I_FOUR;
        alu_function_sel = sel_q;
        done             = !hold;
      end
      ST_ERR:  illegal = err_new_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: per-cycle
// expected outputs queued at issue time.
module tb_instr_sequencer;

  logic       clk;
  logic       reset;
  logic       hold;
  logic [5:0] function_ctr;
  logic [4:0] reg_index;
  logic       reg_r_en, reg_w_en;
  logic       alu1_w_en, alu2_w_en;
  logic       alu0_r_en, imm_en;
  logic [2:0] alu_function_sel;
  logic       done, illegal;

  instr_sequencer_if bus ();

  instr_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .hold             (hold),
    .bus              (bus),
    .function_ctr     (function_ctr),
    .reg_index        (reg_index),
    .reg_r_en         (reg_r_en),
    .reg_w_en         (reg_w_en),
    .alu1_w_en        (alu1_w_en),
    .alu2_w_en        (alu2_w_en),
    .alu0_r_en        (alu0_r_en),
    .imm_en           (imm_en),
    .alu_function_sel (alu_function_sel),
    .done             (done),
    .illegal          (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // en = {reg_r, reg_w, alu1, alu2, alu0, imm}
  typedef struct {
    int         c;
    logic [5:0] fc;
    logic [4:0] ri;
    logic [5:0] en;
    logic [2:0] sel;
    logic       dn;
    logic       ill;
  } exp_t;

  exp_t sb[$];
  bit   hold_cyc[int];
  int   cyc;
  int   n_chk;
  int   n_fail;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h",
               tag, cyc, got, exp);
    end
  endtask

  function automatic logic [2:0] exp_sel(logic [3:0] o);
    case (o)
      4'd0:    return 3'b001;
      4'd1:    return 3'b010;
      4'd2:    return 3'b011;
      4'd3:    return 3'b100;
      4'd4:    return 3'b101;
      4'd5:    return 3'b110;
      4'd8:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic exp_t zrec(int c);
    exp_t e;
    e.c = c; e.fc = '0; e.ri = '0; e.en = '0;
    e.sel = '0; e.dn = 1'b0; e.ill = 1'b0;
    return e;
  endfunction

  task automatic cyc_begin();
    @(posedge clk);
    #1;
    cyc++;
    hold = hold_cyc.exists(cyc);
    bus.instr_valid = 1'b0;
    #1;
  endtask

  task automatic cyc_end();
    exp_t e;
    #1;
    if (sb.size() > 0 && sb[0].c == cyc) e = sb.pop_front();
    else e = zrec(cyc);
    chk("fctr", 32'(function_ctr), 32'(e.fc));
    chk("ridx", 32'(reg_index), 32'(e.ri));
    chk("en", 32'({reg_r_en, reg_w_en, alu1_w_en,
                   alu2_w_en, alu0_r_en, imm_en}), 32'(e.en));
    chk("sel", 32'(alu_function_sel), 32'(e.sel));
    chk("done", 32'(done), 32'(e.dn));
    chk("illegal", 32'(illegal), 32'(e.ill));
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) begin
      cyc_begin();
      cyc_end();
    end
  endtask

  task automatic issue(logic [3:0] o, logic [4:0] d,
                       logic [4:0] s1, logic [4:0] s2,
                       int h2 = 0, int h4 = 0);
    int         n;
    exp_t       e;
    logic [2:0] sl;
    n  = cyc;
    sl = exp_sel(o);
    chk("ready", 32'(bus.instr_ready), 32'd1);
    bus.instr_valid = 1'b1;
    bus.op  = o;
    bus.rd  = d;
    bus.rs1 = s1;
    bus.rs2 = s2;
    if (sl == 3'b000) begin
      e = zrec(n + 1); e.ill = 1'b1; sb.push_back(e);
    end else begin
      e = zrec(n + 1); e.fc = 6'b000001; e.ri = s1;
      e.en = 6'b101000; e.sel = sl; sb.push_back(e);
      for (int i = 0; i <= h2; i++) begin
        e = zrec(n + 2 + i); e.fc = 6'b000010; e.sel = sl;
        if (o == 4'd8) e.en = 6'b000101;
        else begin e.en = 6'b100100; e.ri = s2; end
        sb.push_back(e);
        if (i < h2) hold_cyc[n + 2 + i] = 1'b1;
      end
      e = zrec(n + 3 + h2); e.fc = 6'b000100; e.ri = d;
      e.en = {1'b0, d != 5'd0, 3'b001, 1'b0}; e.sel = sl;
      sb.push_back(e);
      for (int i = 0; i <= h4; i++) begin
        e = zrec(n + 4 + h2 + i); e.fc = 6'b001000;
        e.sel = sl; e.dn = (i == h4);
        sb.push_back(e);
        if (i < h4) hold_cyc[n + 4 + h2 + i] = 1'b1;
      end
    end
  endtask

  initial begin
    cyc = 0; n_chk = 0; n_fail = 0;
    reset = 1'b1; hold = 1'b0;
    bus.instr_valid = 1'b0;
    bus.op = '0; bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0;

    // reset state
    repeat (2) begin cyc_begin(); reset = 1'b1; cyc_end(); end
    cyc_begin(); reset = 1'b0; cyc_end();
    chk("ready_after_rst", 32'(bus.instr_ready), 32'd1);

    // ADD rd3 rs1 1 rs2 2
    cyc_begin(); issue(4'd0, 5'd3, 5'd1, 5'd2); cyc_end();
    run(5);
    // ADDI rd5 rs1 4
    cyc_begin(); issue(4'd8, 5'd5, 5'd4, 5'd9); cyc_end();
    run(5);
    // SUB rd0: write suppressed
    cyc_begin(); issue(4'd1, 5'd0, 5'd6, 5'd7); cyc_end();
    run(5);

    // illegal op 7, ADD accepted in the ERR cycle
    cyc_begin(); issue(4'd7, 5'd1, 5'd1, 5'd1); cyc_end();
    cyc_begin(); issue(4'd0, 5'd9, 5'd10, 5'd11); cyc_end();
    run(5);

    // back-to-back XOR then SLT from S4
    cyc_begin(); issue(4'd4, 5'd12, 5'd13, 5'd14); cyc_end();
    run(3);
    cyc_begin(); issue(4'd5, 5'd15, 5'd16, 5'd17); cyc_end();
    cyc_begin(); chk("ready_s1", 32'(bus.instr_ready), 32'd0);
    cyc_end();
    run(4);

    // OR with hold 2 cycles in S2 and 1 in S4
    cyc_begin(); issue(4'd3, 5'd18, 5'd19, 5'd20, 2, 1); cyc_end();
    run(8);
    // AND, plain
    cyc_begin(); issue(4'd2, 5'd21, 5'd22, 5'd23); cyc_end();
    run(5);

    // hold in IDLE blocks acceptance
    cyc_begin();
    hold = 1'b1; bus.instr_valid = 1'b1; bus.op = 4'd0;
    #1;
    chk("ready_idle_hold", 32'(bus.instr_ready), 32'd0);
    cyc_end();
    run(2);

    // illegal held in ERR: one pulse, ready low until release
    cyc_begin(); issue(4'd15, 5'd1, 5'd2, 5'd3); cyc_end();
    cyc_begin(); hold = 1'b1; #1;
    chk("ready_err_hold", 32'(bus.instr_ready), 32'd0);
    cyc_end();
    cyc_begin(); hold = 1'b1; #1;
    chk("ready_err_hold2", 32'(bus.instr_ready), 32'd0);
    cyc_end();
    cyc_begin();
    chk("ready_err_rel", 32'(bus.instr_ready), 32'd1);
    cyc_end();
    run(1);

    // reset during S2 aborts the instruction
    cyc_begin(); issue(4'd0, 5'd4, 5'd5, 5'd6); cyc_end();
    run(1);
    cyc_begin(); reset = 1'b1; cyc_end();
    sb.delete();
    cyc_begin(); reset = 1'b0; cyc_end();
    chk("ready_post_abort", 32'(bus.instr_ready), 32'd1);
    run(3);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Central micro-sequencer for the MkII execute path.
- Accepts one decoded instruction per valid/ready handshake and steps a one-hot step counter (I_ONE..I_FOUR).
- Each step drives the single shared set of register-file, ALU-latch and immediate enables.
- Replaces the per-instruction tri-state control fan-in: outputs are always driven to 0 or 1, never Z.

Parameters:
- REG_AW, 5, register index width (rd/rs1/rs2/reg_index).
- ALU_SEL_W, 3, alu_function_sel width.
- OP_W, 4, opcode width.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- instr_valid  input  1  instruction fields valid
- instr_ready  output  1  sequencer can accept an instruction this cycle
- op  input  OP_W  opcode
- rd  input  REG_AW  destination register
- rs1  input  REG_AW  source register 1
- rs2  input  REG_AW  source register 2
- hold  input  1  stall request from the datapath
- function_ctr  output  6  current one-hot step (I_NONE when idle)
- reg_index  output  REG_AW  register-file index
- reg_r_en  output  1  register-file read enable
- reg_w_en  output  1  register-file write enable
- alu1_w_en  output  1  load ALU operand latch 1
- alu2_w_en  output  1  load ALU operand latch 2
- alu0_r_en  output  1  drive ALU result onto the write bus
- imm_en  output  1  drive the immediate onto the operand bus
- alu_function_sel  output  ALU_SEL_W  ALU operation
- done  output  1  one-cycle instruction-complete strobe
- illegal  output  1  one-cycle strobe: unsupported opcode rejected

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: state IDLE, function_ctr=I_NONE (6'b000000), every enable 0, reg_index 0, alu_function_sel 0, done 0, illegal 0, latched fields 0. instr_ready becomes 1 on the first cycle after reset deasserts (if hold=0).
- Reset mid-instruction: abort immediately. No done, and no reg_w_en on the following cycle.
- States: IDLE, S1, S2, S3, S4, ERR. function_ctr is I_NONE, I_ONE, I_TWO, I_THREE, I_FOUR, I_NONE respectively.
- instr_ready = !hold && (state==IDLE || state==S4 || state==ERR).
- Accept: when instr_valid && instr_ready, latch op/rd/rs1/rs2. A legal op goes to S1; an illegal op goes to ERR.
- Opcode map (op -> alu_function_sel):
  - ADD=0 -> 001
  - SUB=1 -> 010
  - AND=2 -> 011
  - OR=3 -> 100
  - XOR=4 -> 101
  - SLT=5 -> 110
  - ADDI=8 -> 001
  - All other values are illegal.
- alu_function_sel holds the latched op's code in S1..S4 and is 0 otherwise.
- S1: reg_index=rs1, reg_r_en=1, alu1_w_en=1.
- S2, R-type: reg_index=rs2, reg_r_en=1, alu2_w_en=1.
- S2, ADDI: imm_en=1, alu2_w_en=1, reg_r_en=0, reg_index=0.
- S3: reg_index=rd, alu0_r_en=1. reg_w_en=1 unless rd==0; x0 writes are suppressed but the step still executes.
- S4: done=1 when hold=0; no enables.
- ERR: illegal=1 for exactly one cycle, no enables, no done.
- Return from S4 or ERR: IDLE if nothing is accepted that cycle. Back-to-back issue from S4/ERR goes straight to S1/ERR.
- Latency: accept at cycle N gives S1 at N+1, S2 at N+2, S3 at N+3, done at N+4. Sustained throughput is 1 instruction per 4 cycles.
- Hold:
  - In S1..S4, hold=1 freezes state, latched fields and all step outputs (enables stay asserted).
  - done is suppressed while held in S4 and fires on the first cycle hold=0.
  - In IDLE, hold only blocks acceptance.
  - In ERR, hold does not extend the illegal pulse, but the sequencer stays in ERR (ready low) until hold=0.
- Outputs are registered-state decodes: no combinational path from instr_valid/op to any enable.
- instr_ready depends combinationally on hold.

Decomposition:
- Shared package mkii_ctrl_pkg holds:
  - INSTRUCTION_COUNT one-hot step enum (I_NONE..I_SIX);
  - opcode enum OPCODE_T (OP_ADD..OP_SLT, OP_ADDI);
  - ALU select constants ALU_ADD..ALU_SLT.
- Sub-module instr_decode, combinational: op -> {legal, uses_imm, alu_sel}. Instantiated once; the result is latched on accept.

Test Plan:
- ADD rd=3 rs1=1 rs2=2 accepted at cycle 0, hold=0 -> cycle 1: I_ONE, reg_index=1, reg_r_en, alu1_w_en. Cycle 2: reg_index=2, alu2_w_en. Cycle 3: reg_index=3, reg_w_en, alu0_r_en. Cycle 4: done=1. alu_function_sel=001 throughout.
- ADDI rd=5 rs1=4 -> cycle 2: imm_en=1, alu2_w_en=1, reg_r_en=0. Cycle 3: reg_w_en=1 with reg_index=5.
- SUB rd=0 -> cycle 3: alu0_r_en=1, reg_w_en=0. Cycle 4: done=1. alu_function_sel=010.
- op=7 -> next cycle illegal=1, done never asserts, no enables. instr_ready=1 in that cycle; a following ADD is accepted there and enters S1.
- Back-to-back: second instruction valid during S4 -> accepted in S4, S1 on the next cycle (no IDLE gap). hold=1 for 2 cycles in S2 -> S2 outputs held 3 cycles, done slips by 2.
- reset=1 during S2 -> next cycle function_ctr=0, all enables 0, no done. Cycle after reset deasserts: instr_ready=1.
